hash_request_master: RTL and testbench
======================================

Name: hash_request_master

Overview:
- Initiator-side front end for the hash table. It accepts a command stream (op, key, data, last), issues one request per cycle into the table's request port, and captures each one-cycle-later response.
- Responses are packed into a status-coded result stream through a local result FIFO. It drives the table's stall/advance input so that no response is ever lost.
- Sits between the host/packet parser and the hash table; the hash table is the responder.

Parameters:
- KEY_WIDTH, 2, key width; must match the hash table.
- DATA_WIDTH, 32, data width; must match the hash table.
- KEEP_WIDTH, 8, width of the keep sideband.
- RESP_DEPTH, 4, result FIFO depth; power of 2, ≥2.
- STAT_WIDTH, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o
- cmd_op_i  in  2  01 read, 10 write, 11 delete, 00 nop
- cmd_key_i  in  KEY_WIDTH  key
- cmd_data_i  in  DATA_WIDTH  write data
- cmd_last_i  in  1  last command of a burst
- cmd_keep_i  in  KEEP_WIDTH  sideband, returned unchanged
- tbl_key_o  out  KEY_WIDTH  key to table
- tbl_data_o  out  DATA_WIDTH  data to table
- tbl_op_o  out  2  op to table
- tbl_valid_o  out  1  request valid to table
- tbl_ready_o  out  1  table pipeline advance/stall
- tbl_read_data_i  in  DATA_WIDTH  table read data
- tbl_no_deletion_target_i  in  1  table error flag
- tbl_no_write_space_i  in  1  table error flag
- tbl_no_element_found_i  in  1  table error flag
- tbl_key_already_present_i  in  1  table error flag
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumer ready
- res_data_o  out  DATA_WIDTH  read data; 0 for non-read ops
- res_key_o  out  KEY_WIDTH  key of the command
- res_status_o  out  3  0 OK, 1 NOT_FOUND, 2 NO_SPACE, 3 NO_DEL_TARGET, 4 KEY_PRESENT
- res_last_o  out  1  echoed last
- res_keep_o  out  KEEP_WIDTH  echoed keep
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when a burst has fully drained

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO count 0; inflight 0; state IDLE.
- Issue condition: issue = cmd_valid_i && cmd_op_i != 00 && state != DRAIN && (count + inflight) < RESP_DEPTH.
- cmd_ready_o:
  - Equals the issue condition with cmd_valid_i removed.
  - Nop commands (cmd_op_i = 00) are consumed with cmd_ready_o = 1 whenever state != DRAIN. They produce no table request and no result.
- tbl_valid_o = issue. tbl_key_o, tbl_data_o and tbl_op_o drive cmd_* combinationally; tbl_op_o = 00 when issue = 0.
- tbl_ready_o = inflight || ((count + inflight) < RESP_DEPTH). It is forced high during every response cycle so the table's write commits.
- Latency: a request issued in cycle N has its response visible in cycle N+1.
  - In N+1 with inflight = 1, the response is pushed into the FIFO.
  - Pushed fields: op, key, last and keep are held in a 1-entry side register captured at issue.
  - inflight(N+1) = issue(N).
- Status encoding:
  - Priority order: no_element_found → 1; no_write_space → 2; no_deletion_target → 3; key_already_present → 4; else 0.
  - Flags are ignored when they do not match the op (e.g. no_write_space on a read counts as OK).
- res_data_o = tbl_read_data_i only for op 01; otherwise 0.
- Result FIFO:
  - Push and pop may happen in the same cycle; count is unchanged.
  - A pop on empty and a push on full are impossible by construction; an assertion covers this.
- FSM:
  - IDLE → RUN on the first issue.
  - RUN → DRAIN on an issue with cmd_last_i = 1.
  - DRAIN waits for inflight = 0 and count = 0, then pulses done_o for 1 cycle → IDLE.
  - Commands are not accepted in DRAIN.
  - A last on a nop in RUN also goes to DRAIN; a last on a nop in IDLE pulses done_o directly.
- Reset mid-operation (reset low): all state is cleared immediately. In-flight and buffered results are discarded; the table pipeline is reset by the same reset.

Optional Feature:
- Macro HASH_REQ_STATS_EN.
- When defined: add outputs stat_ops_o and stat_errs_o, both STAT_WIDTH bits.
  - stat_ops_o increments on every FIFO push.
  - stat_errs_o increments on every push with status != 0.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Write key 2, data 0xA5A5A5A5, then read key 2 (last = 1) → results: status 0 data 0; then status 0, data 0xA5A5A5A5, last = 1; done_o pulses once after the second pop.
- Read key 1 never written → status 1, res_data_o = 0.
- Write key 3 twice → second result has status 4; delete key 0 never written → status 3.
- RESP_DEPTH = 4, res_ready_i = 0, 6 back-to-back reads → exactly 4 accepted; cmd_ready_o low afterwards; tbl_ready_o high on each response cycle. Raising res_ready_i releases all 6 results in order with no loss.
- Nop-heavy stream (00, 01, 00, 10) → only 2 table requests and 2 results; result key order preserved.
- Assert reset low with 2 results buffered and 1 in flight → all outputs 0 next edge; after release, a read of key 2 returns NOT_FOUND (table cleared).

Source files
------------

// File: rtl/hash_request_master.sv
// hash_request_master: initiator-side front end for the hash table.
// Accepts a command stream and issues at most one table request per cycle.
// Captures each response one cycle later and queues a status-coded result
// in a small FIFO. The table is stalled whenever the FIFO could not absorb
// another response.
// Optional statistics counters are enabled with `define HASH_REQ_STATS_EN.
// Handshake rule on every interface: a transfer happens on a rising edge
// where valid && ready are both high. Valid never waits for ready, and a
// result stays stable while res_valid_o is high and res_ready_i is low.
module hash_request_master #(
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 8,
    parameter int RESP_DEPTH = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [KEY_WIDTH-1:0]  cmd_key_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    input  logic                  cmd_last_i,
    input  logic [KEEP_WIDTH-1:0] cmd_keep_i,
    output logic [KEY_WIDTH-1:0]  tbl_key_o,
    output logic [DATA_WIDTH-1:0] tbl_data_o,
    output logic [1:0]            tbl_op_o,
    output logic                  tbl_valid_o,
    output logic                  tbl_ready_o,
    input  logic [DATA_WIDTH-1:0] tbl_read_data_i,
    input  logic                  tbl_no_deletion_target_i,
    input  logic                  tbl_no_write_space_i,
    input  logic                  tbl_no_element_found_i,
    input  logic                  tbl_key_already_present_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic [KEY_WIDTH-1:0]  res_key_o,
    output logic [2:0]            res_status_o,
    output logic                  res_last_o,
    output logic [KEEP_WIDTH-1:0] res_keep_o,
    output logic                  busy_o,
    output logic [1:0]            dbg_state_o,
    output logic                  done_o
`ifdef HASH_REQ_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_ops_o,
    output logic [STAT_WIDTH-1:0] stat_errs_o
`endif
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int EW = DATA_WIDTH + KEY_WIDTH + 3 + 1 + KEEP_WIDTH;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(RESP_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                state_q, state_d;
    logic                  run_en_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            side_op_q, side_op_d;
    logic [KEY_WIDTH-1:0]  side_key_q, side_key_d;
    logic                  side_last_q, side_last_d;
    logic [KEEP_WIDTH-1:0] side_keep_q, side_keep_d;
    logic [EW-1:0]         mem_q [RESP_DEPTH];

    logic [CW:0]           occupancy;
    logic                  space, issue, nop_take, push, pop, empty;
    logic [2:0]            status;
    logic [DATA_WIDTH-1:0] push_data;
    logic [EW-1:0]         push_entry;

    // Issue decision: a slot is reserved for every response already in flight,
    // so a request only goes out when the FIFO can take its response.
    always_comb begin
        occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        space       = occupancy < DEPTH_V;
        issue       = run_en_q && cmd_valid_i && (cmd_op_i != 2'b00) && (state_q != DRAIN) && space;
        nop_take    = run_en_q && cmd_valid_i && (cmd_op_i == 2'b00) && (state_q != DRAIN);
        cmd_ready_o = run_en_q && (state_q != DRAIN) && ((cmd_op_i == 2'b00) || space);
        tbl_valid_o = issue;
        tbl_op_o    = issue ? cmd_op_i : 2'b00;
        tbl_key_o   = cmd_key_i;
        tbl_data_o  = cmd_data_i;
        tbl_ready_o = run_en_q && (inflight_q || space);
    end

    // Response decode: only flags meaningful for the captured op contribute.
    always_comb begin
        status = 3'd0;
        case (side_op_q)
            2'b01:   status = tbl_no_element_found_i ? 3'd1 : 3'd0;
            2'b10:   status = tbl_no_write_space_i ? 3'd2 :
                              (tbl_key_already_present_i ? 3'd4 : 3'd0);
            2'b11:   status = tbl_no_deletion_target_i ? 3'd3 : 3'd0;
            default: status = 3'd0;
        endcase
        push_data  = (side_op_q == 2'b01) ? tbl_read_data_i : '0;
        push_entry = {push_data, side_key_q, status, side_last_q, side_keep_q};
    end

    // FIFO bookkeeping and the one-entry side register for the in-flight request.
    always_comb begin
        push     = inflight_q;
        empty    = (count_q == '0);
        pop      = !empty && res_ready_i;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        inflight_d  = issue;
        side_op_d   = issue ? cmd_op_i   : side_op_q;
        side_key_d  = issue ? cmd_key_i  : side_key_q;
        side_last_d = issue ? cmd_last_i : side_last_q;
        side_keep_d = issue ? cmd_keep_i : side_keep_q;
    end

    // Burst FSM: IDLE -> RUN on first issue, DRAIN after a last, done when empty.
    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) state_d = cmd_last_i ? DRAIN : RUN;
                else if (nop_take && cmd_last_i) done_o = 1'b1;
            end
            RUN: begin
                if ((issue || nop_take) && cmd_last_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!inflight_q && empty) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result port: head of the FIFO, held at zero while empty.
    always_comb begin
        res_valid_o = !empty;
        {res_data_o, res_key_o, res_status_o, res_last_o, res_keep_o} =
            empty ? '0 : mem_q[rd_ptr_q];
        busy_o      = (state_q != IDLE);
        dbg_state_o = state_q;
    end

    // Control state; reset discards buffered and in-flight results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_en_q    <= 1'b0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            side_op_q   <= 2'b00;
            side_key_q  <= '0;
            side_last_q <= 1'b0;
            side_keep_q <= '0;
        end else begin
            state_q     <= state_d;
            run_en_q    <= 1'b1;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            side_op_q   <= side_op_d;
            side_key_q  <= side_key_d;
            side_last_q <= side_last_d;
            side_keep_q <= side_keep_d;
        end
    end

    // FIFO storage; contents are only visible through the count-gated head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    // Occupancy never exceeds the FIFO, so a push never lands on a full FIFO.
    assert property (@(posedge clk) disable iff (!run_en_q) occupancy <= DEPTH_V);
    assert property (@(posedge clk) disable iff (!run_en_q)
        !(push && (count_q == CW'(RESP_DEPTH))));
    assert property (@(posedge clk) (RESP_DEPTH >= 2) && (STAT_WIDTH >= 1));

`ifdef HASH_REQ_STATS_EN
    logic [STAT_WIDTH-1:0] stat_ops_q, stat_ops_d, stat_errs_q, stat_errs_d;

    // Saturating push and error-push counters.
    always_comb begin
        stat_ops_d  = stat_ops_q;
        stat_errs_d = stat_errs_q;
        if (push && !(&stat_ops_q)) stat_ops_d = stat_ops_q + STAT_WIDTH'(1);
        if (push && (status != 3'd0) && !(&stat_errs_q)) stat_errs_d = stat_errs_q + STAT_WIDTH'(1);
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ops_q  <= '0;
            stat_errs_q <= '0;
        end else begin
            stat_ops_q  <= stat_ops_d;
            stat_errs_q <= stat_errs_d;
        end
    end

    assign stat_ops_o  = stat_ops_q;
    assign stat_errs_o = stat_errs_q;
`endif

endmodule

// File: tb/tb_hash_request_master.sv
// Bench for hash_request_master: behavioural hash table responder plus a
// transaction-level model of issue/ready/done and an expected result queue.
module tb_hash_request_master;

    localparam int KW = 2, DW = 32, KPW = 8, DEPTH = 4, SW = 16;
    localparam int RW = DW + KW + 3 + 1 + KPW;
    localparam int CAP = 3;

    typedef struct packed {
        logic [1:0]     op;
        logic [KW-1:0]  key;
        logic [DW-1:0]  data;
        logic           last;
        logic [KPW-1:0] keep;
    } cmd_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           cmd_valid_i = 1'b0, cmd_ready_o;
    logic [1:0]     cmd_op_i = '0;
    logic [KW-1:0]  cmd_key_i = '0;
    logic [DW-1:0]  cmd_data_i = '0;
    logic           cmd_last_i = 1'b0;
    logic [KPW-1:0] cmd_keep_i = '0;
    logic [KW-1:0]  tbl_key_o;
    logic [DW-1:0]  tbl_data_o;
    logic [1:0]     tbl_op_o;
    logic           tbl_valid_o, tbl_ready_o;
    logic [DW-1:0]  tbl_read_data_i = '0;
    logic           tbl_no_deletion_target_i = 1'b0, tbl_no_write_space_i = 1'b0;
    logic           tbl_no_element_found_i = 1'b0, tbl_key_already_present_i = 1'b0;
    logic           res_valid_o, res_ready_i = 1'b0;
    logic [DW-1:0]  res_data_o;
    logic [KW-1:0]  res_key_o;
    logic [2:0]     res_status_o;
    logic           res_last_o;
    logic [KPW-1:0] res_keep_o;
    logic           busy_o, done_o;
    logic [1:0]     dbg_state_o;
`ifdef HASH_REQ_STATS_EN
    logic [SW-1:0]  stat_ops_o, stat_errs_o;
`endif

    always #5 clk = ~clk;

    hash_request_master #(
        .KEY_WIDTH(KW), .DATA_WIDTH(DW), .KEEP_WIDTH(KPW), .RESP_DEPTH(DEPTH), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_key_i(cmd_key_i), .cmd_data_i(cmd_data_i), .cmd_last_i(cmd_last_i),
        .cmd_keep_i(cmd_keep_i),
        .tbl_key_o(tbl_key_o), .tbl_data_o(tbl_data_o), .tbl_op_o(tbl_op_o),
        .tbl_valid_o(tbl_valid_o), .tbl_ready_o(tbl_ready_o),
        .tbl_read_data_i(tbl_read_data_i),
        .tbl_no_deletion_target_i(tbl_no_deletion_target_i),
        .tbl_no_write_space_i(tbl_no_write_space_i),
        .tbl_no_element_found_i(tbl_no_element_found_i),
        .tbl_key_already_present_i(tbl_key_already_present_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_key_o(res_key_o), .res_status_o(res_status_o), .res_last_o(res_last_o),
        .res_keep_o(res_keep_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o), .done_o(done_o)
`ifdef HASH_REQ_STATS_EN
        , .stat_ops_o(stat_ops_o), .stat_errs_o(stat_errs_o)
`endif
    );

    // Scoreboard and model state
    int n_checks = 0, n_errors = 0;
    logic [RW-1:0] exp_q[$];
    cmd_t cmd_q[$];
    logic          iss_v = 1'b0, resp_v = 1'b0;
    logic [RW-1:0] iss_e, resp_e;
    logic [DW-1:0] iss_rd, resp_rd;
    logic [3:0]    iss_fl, resp_fl;   // {no_element_found, no_write_space, no_deletion_target, key_present}
    logic          draining = 1'b0, active = 1'b0;
    logic          present [4];
    logic [DW-1:0] val [4];
    int            tbl_cnt = 0;
    int            valid_pct = 100, rr_pct = 100;
    int            n_acc = 0, n_req = 0, n_pop = 0, n_done = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [1:0] op, input int key, input logic [DW-1:0] data,
                            input logic last);
        cmd_t c;
        c.op = op; c.key = KW'(key); c.data = data; c.last = last;
        c.keep = KPW'($urandom_range(255));
        cmd_q.push_back(c);
    endtask

    task automatic clear_model();
        exp_q.delete();
        iss_v = 1'b0; resp_v = 1'b0; draining = 1'b0; active = 1'b0; tbl_cnt = 0;
        for (int i = 0; i < 4; i++) begin present[i] = 1'b0; val[i] = '0; end
    endtask

    // Hash table semantics; mismatched error flags are driven at random.
    task automatic tbl_access(input cmd_t c);
        logic [2:0]    st;
        logic [3:0]    fl;
        logic [DW-1:0] rd;
        st = 3'd0;
        rd = $urandom();
        fl = 4'($urandom_range(15));
        case (c.op)
            2'b01: begin
                fl[3] = !present[c.key];
                if (present[c.key]) rd = val[c.key];
                else st = 3'd1;
            end
            2'b10: begin
                fl[2] = 1'b0; fl[0] = 1'b0;
                if (present[c.key]) begin fl[0] = 1'b1; st = 3'd4; end
                else if (tbl_cnt >= CAP) begin fl[2] = 1'b1; st = 3'd2; end
                else begin present[c.key] = 1'b1; val[c.key] = c.data; tbl_cnt++; end
            end
            default: begin
                fl[1] = !present[c.key];
                if (present[c.key]) begin present[c.key] = 1'b0; tbl_cnt--; end
                else st = 3'd3;
            end
        endcase
        iss_v  = 1'b1;
        iss_rd = rd;
        iss_fl = fl;
        iss_e  = {(c.op == 2'b01) ? rd : {DW{1'b0}}, c.key, st, c.last, c.keep};
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, advance model.
    task automatic step();
        cmd_t c;
        logic v, exp_ready, exp_issue, exp_done, exp_tready;
        int   outst;
        @(negedge clk);
        if (resp_v) exp_q.push_back(resp_e);
        resp_v = iss_v; resp_e = iss_e; resp_rd = iss_rd; resp_fl = iss_fl;
        iss_v = 1'b0;
        if (resp_v) begin
            tbl_read_data_i = resp_rd;
            {tbl_no_element_found_i, tbl_no_write_space_i,
             tbl_no_deletion_target_i, tbl_key_already_present_i} = resp_fl;
        end else begin
            tbl_read_data_i = $urandom();
            {tbl_no_element_found_i, tbl_no_write_space_i,
             tbl_no_deletion_target_i, tbl_key_already_present_i} = 4'($urandom_range(15));
        end
        c = '0;
        if (cmd_q.size() != 0) c = cmd_q[0];
        v = (cmd_q.size() != 0) && ($urandom_range(99) < valid_pct);
        cmd_valid_i = v; cmd_op_i = c.op; cmd_key_i = c.key; cmd_data_i = c.data;
        cmd_last_i = c.last; cmd_keep_i = c.keep;
        res_ready_i = ($urandom_range(99) < rr_pct);
        #1;
        outst      = exp_q.size() + (resp_v ? 1 : 0);
        exp_ready  = !draining && ((c.op == 2'b00) || (outst < DEPTH));
        exp_issue  = v && (c.op != 2'b00) && exp_ready;
        exp_done   = (draining && outst == 0) ||
                     (!active && !draining && v && c.op == 2'b00 && c.last);
        exp_tready = resp_v || (outst < DEPTH);
        check("cmd_ready", cmd_ready_o, exp_ready);
        check("tbl_valid", tbl_valid_o, exp_issue);
        check("tbl_op", tbl_op_o, exp_issue ? c.op : 2'b00);
        if (exp_issue) begin
            check("tbl_key", tbl_key_o, c.key);
            check("tbl_data", tbl_data_o, c.data);
        end
        check("tbl_ready", tbl_ready_o, exp_tready);
        check("done", done_o, exp_done);
        check("busy", busy_o, active || draining);
        check("res_valid", res_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0)
            check("res_fields", {res_data_o, res_key_o, res_status_o, res_last_o, res_keep_o},
                  exp_q[0]);
        if (cmd_valid_i && cmd_ready_o) n_acc++;
        if (tbl_valid_o) n_req++;
        if (res_valid_o && res_ready_i) n_pop++;
        if (done_o) n_done++;
        if (exp_q.size() != 0 && res_ready_i) void'(exp_q.pop_front());
        if (draining && outst == 0) begin
            draining = 1'b0; active = 1'b0;
        end else if (v && exp_ready) begin
            void'(cmd_q.pop_front());
            if (c.op != 2'b00) begin
                tbl_access(c);
                active = 1'b1;
                if (c.last) draining = 1'b1;
            end else if (c.last && active) begin
                draining = 1'b1;
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((cmd_q.size() != 0 || exp_q.size() != 0 || iss_v || resp_v || draining) && n < budget) begin
            step();
            n++;
        end
        check("idle_budget", (n >= budget) ? 1 : 0, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 0);
        check({tag, "_tbl_ctl"}, {tbl_valid_o, tbl_ready_o, tbl_op_o}, 0);
        check({tag, "_tbl_kd"}, {tbl_key_o, tbl_data_o}, 0);
        check({tag, "_res_valid"}, res_valid_o, 0);
        check({tag, "_res"}, {res_data_o, res_key_o, res_status_o, res_last_o, res_keep_o}, 0);
        check({tag, "_busy_done"}, {busy_o, done_o, dbg_state_o}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_key_i = '0; cmd_data_i = '0;
        cmd_last_i = 1'b0; cmd_keep_i = '0; res_ready_i = 1'b0;
        tbl_read_data_i = '0;
        {tbl_no_element_found_i, tbl_no_write_space_i,
         tbl_no_deletion_target_i, tbl_key_already_present_i} = 4'b0;
        #1;
        check_zero("rst_now");
        clear_model();
        @(negedge clk);
        #1;
        check_zero("rst_hold");
        reset = 1'b1;
    endtask

    initial begin
        int base_a, base_p, base_r, base_d;
        clear_model();
        do_reset();

        // Write then read back the same key
        base_d = n_done;
        push_cmd(2'b10, 2, 32'hA5A5A5A5, 1'b0);
        push_cmd(2'b01, 2, '0, 1'b1);
        run_until_idle(50);
        check("wr_rd_done_once", n_done - base_d, 1);

        // Read of an absent key, duplicate write, delete of an absent key
        push_cmd(2'b01, 1, '0, 1'b1);
        run_until_idle(50);
        push_cmd(2'b10, 3, $urandom(), 1'b0);
        push_cmd(2'b10, 3, $urandom(), 1'b0);
        push_cmd(2'b11, 0, '0, 1'b1);
        run_until_idle(50);

        // Result back-pressure: only DEPTH requests may be outstanding
        rr_pct = 0;
        base_a = n_acc;
        for (int i = 0; i < 6; i++) push_cmd(2'b01, i % 4, '0, i == 5);
        repeat (10) step();
        check("bp_accepted", n_acc - base_a, 4);
        rr_pct = 100;
        base_p = n_pop;
        run_until_idle(100);
        check("bp_released", n_pop - base_p, 6);
        check("bp_total_acc", n_acc - base_a, 6);

        // Nop-heavy stream
        base_r = n_req; base_p = n_pop;
        push_cmd(2'b00, 0, '0, 1'b0);
        push_cmd(2'b01, 3, '0, 1'b0);
        push_cmd(2'b00, 2, '0, 1'b0);
        push_cmd(2'b10, 1, $urandom(), 1'b1);
        run_until_idle(50);
        check("nop_requests", n_req - base_r, 2);
        check("nop_results", n_pop - base_p, 2);

        // Last on a nop while idle
        base_d = n_done;
        push_cmd(2'b00, 0, '0, 1'b1);
        run_until_idle(20);
        check("nop_last_idle_done", n_done - base_d, 1);

        // Reset with two results buffered and one in flight
        rr_pct = 0;
        push_cmd(2'b10, 2, $urandom(), 1'b0);
        push_cmd(2'b10, 1, $urandom(), 1'b0);
        push_cmd(2'b10, 0, $urandom(), 1'b0);
        repeat (3) step();
        do_reset();
        rr_pct = 100;
        push_cmd(2'b01, 2, '0, 1'b1);
        run_until_idle(50);

        // Randomized traffic
        valid_pct = 70;
        for (int phase = 0; phase < 2; phase++) begin
            rr_pct = (phase == 0) ? 30 : 90;
            for (int i = 0; i < 150; i++)
                push_cmd(2'($urandom_range(3)), $urandom_range(3), $urandom(),
                         $urandom_range(9) == 0);
            run_until_idle(4000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
